// File: rtl/reg_types_pkg.sv
// Shared register-file types: data/index types, zero-register constants, file request bundle.
// Also holds the operand-fetch state encoding and the writeback hit helper.
package reg_types_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       reg_data_t;
    typedef logic [REG_ADDR_W-1:0] reg_index_t;

    localparam reg_index_t REG_ZERO     = '0;
    localparam reg_data_t  REG_ZERO_VAL = '0;

    // Request side of the register-file port pair (read data returns separately).
    typedef struct packed {
        reg_index_t read_reg_addr_1;
        reg_index_t read_reg_addr_2;
        reg_index_t write_reg_addr;
        reg_data_t  write_data;
        logic       write_enable;
    } reg_file_io_t;

    typedef enum logic {
        OF_EMPTY = 1'b0,
        OF_FULL  = 1'b1
    } of_state_e;

    // x0 is hardwired, so a write to it must never look like a hit.
    function automatic logic wb_hits(input logic en, input reg_index_t wa, input reg_index_t a);
        return en && (wa == a) && (a != REG_ZERO);
    endfunction

endpackage

// File: rtl/operand_bypass_m.sv
// One operand's bypass: captures a writeback that lands on the edge the file is read,
// then selects x0 / live writeback / captured writeback / file data, zeroed when not valid.
module operand_bypass_m
    import reg_types_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       valid,
    input  reg_index_t rd_addr,
    input  reg_index_t held_rs,
    input  logic       wb_en,
    input  reg_index_t wb_addr,
    input  reg_data_t  wb_data,
    input  reg_data_t  rf_data,
    output reg_data_t  operand
);

    logic      hit_q;
    reg_data_t data_q;

    // The file returns the pre-write value when read and write share an edge.
    always_ff @(posedge clk) begin
        if (clear) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= wb_hits(wb_en, wb_addr, rd_addr);
        end
        data_q <= wb_data;
    end

    always_comb begin
        operand = REG_ZERO_VAL;
        if (!valid || held_rs == REG_ZERO) begin
            operand = REG_ZERO_VAL;
        end else if (wb_en && wb_addr == held_rs) begin
            operand = wb_data;
        end else if (hit_q) begin
            operand = data_q;
        end else begin
            operand = rf_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch between decode and execute: one-entry holding stage over a 1-cycle register file.
// Latency 1, throughput 1/cycle; in_ready drops only when full and execute stalls, or on flush/reset.
module operand_fetch
    import reg_types_pkg::*;
#(
    parameter int TAG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  reg_index_t           in_rs1,
    input  reg_index_t           in_rs2,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output reg_data_t            out_rs1_data,
    output reg_data_t            out_rs2_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    input  logic                 flush,
    input  logic                 wb_en,
    input  reg_index_t           wb_addr,
    input  reg_data_t            wb_data,
    output reg_index_t           rf_read_reg_addr_1,
    output reg_index_t           rf_read_reg_addr_2,
    output reg_index_t           rf_write_reg_addr,
    output reg_data_t            rf_write_data,
    output logic                 rf_write_enable,
    input  reg_data_t            rf_read_data_1,
    input  reg_data_t            rf_read_data_2
);

    of_state_e            state_q, state_d;
    reg_index_t           rs1_q, rs2_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 out_valid_q;
    logic                 accept;
    reg_file_io_t         rf_req;

    assign out_valid_q = (state_q == OF_FULL);
    assign in_ready    = !reset && !flush && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OF_EMPTY: begin
                if (accept) state_d = OF_FULL;
            end
            OF_FULL: begin
                if (flush)                     state_d = OF_EMPTY;
                else if (out_ready && !accept) state_d = OF_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_q <= REG_ZERO;
            rs2_q <= REG_ZERO;
            tag_q <= '0;
        end else if (accept) begin
            rs1_q <= in_rs1;
            rs2_q <= in_rs2;
            tag_q <= in_tag;
        end
    end

    // Re-reading the held indices every cycle keeps a stalled entry current.
    always_comb begin
        rf_req.read_reg_addr_1 = accept ? in_rs1 : rs1_q;
        rf_req.read_reg_addr_2 = accept ? in_rs2 : rs2_q;
        rf_req.write_reg_addr  = wb_addr;
        rf_req.write_data      = wb_data;
        rf_req.write_enable    = wb_en && !reset;
    end

    assign rf_read_reg_addr_1 = rf_req.read_reg_addr_1;
    assign rf_read_reg_addr_2 = rf_req.read_reg_addr_2;
    assign rf_write_reg_addr  = rf_req.write_reg_addr;
    assign rf_write_data      = rf_req.write_data;
    assign rf_write_enable    = rf_req.write_enable;

    operand_bypass_m u_byp_rs1 (
        .clk     (clk),
        .clear   (reset || flush),
        .valid   (out_valid_q),
        .rd_addr (rf_req.read_reg_addr_1),
        .held_rs (rs1_q),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .rf_data (rf_read_data_1),
        .operand (out_rs1_data)
    );

    operand_bypass_m u_byp_rs2 (
        .clk     (clk),
        .clear   (reset || flush),
        .valid   (out_valid_q),
        .rd_addr (rf_req.read_reg_addr_2),
        .held_rs (rs2_q),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .rf_data (rf_read_data_2),
        .operand (out_rs2_data)
    );

    assign out_valid = out_valid_q;
    assign out_tag   = out_valid_q ? tag_q : '0;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: models the register file plus an architectural register view,
// and checks every cycle against the expected pipeline contents.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, flush;
    logic [4:0]  in_rs1, in_rs2, wb_addr;
    logic [31:0] in_tag, out_tag, out_rs1_data, out_rs2_data, wb_data;
    logic        wb_en, rf_write_enable;
    logic [4:0]  rf_read_reg_addr_1, rf_read_reg_addr_2, rf_write_reg_addr;
    logic [31:0] rf_write_data, rf_read_data_1, rf_read_data_2;

    int checks = 0;
    int errors = 0;

    // Environment register file: registered read, read-before-write on a shared edge.
    logic [31:0] regs [32];

    // Reference model: architectural register contents and the presented instruction.
    logic [31:0] arch [32];
    logic        mv;
    logic [4:0]  mrs1, mrs2;
    logic [31:0] mtag;

    always #5 clk = ~clk;

    operand_fetch #(.TAG_WIDTH(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_rs1             (in_rs1),
        .in_rs2             (in_rs2),
        .in_tag             (in_tag),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_rs1_data       (out_rs1_data),
        .out_rs2_data       (out_rs2_data),
        .out_tag            (out_tag),
        .flush              (flush),
        .wb_en              (wb_en),
        .wb_addr            (wb_addr),
        .wb_data            (wb_data),
        .rf_read_reg_addr_1 (rf_read_reg_addr_1),
        .rf_read_reg_addr_2 (rf_read_reg_addr_2),
        .rf_write_reg_addr  (rf_write_reg_addr),
        .rf_write_data      (rf_write_data),
        .rf_write_enable    (rf_write_enable),
        .rf_read_data_1     (rf_read_data_1),
        .rf_read_data_2     (rf_read_data_2)
    );

    always @(posedge clk) begin
        rf_read_data_1 <= regs[rf_read_reg_addr_1];
        rf_read_data_2 <= regs[rf_read_reg_addr_2];
        if (rf_write_enable) regs[rf_write_reg_addr] <= rf_write_data;
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Architecturally current value of a register as seen in this cycle.
    function automatic logic [31:0] cur_val(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_en && wb_addr == r) return wb_data;
        return arch[r];
    endfunction

    task automatic tick();
        logic       rdy, acc, s_reset, s_flush, s_ordy, s_wb;
        logic [4:0] s_rs1, s_rs2, s_wa;
        logic [31:0] s_tag, s_wd;
        @(negedge clk);
        rdy = !reset && !flush && (!mv || out_ready);
        acc = in_valid && rdy;
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, mv);
        chk("out_tag", out_tag, mv ? mtag : 32'd0);
        chk("out_rs1_data", out_rs1_data, mv ? cur_val(mrs1) : 32'd0);
        chk("out_rs2_data", out_rs2_data, mv ? cur_val(mrs2) : 32'd0);
        chk("rf_write_enable", rf_write_enable, wb_en && !reset);
        if (wb_en) chk("rf_write", {rf_write_reg_addr, rf_write_data}, {wb_addr, wb_data});
        if (acc) chk("rf_read_addr_new", {rf_read_reg_addr_1, rf_read_reg_addr_2}, {in_rs1, in_rs2});
        else if (mv) chk("rf_read_addr_held", {rf_read_reg_addr_1, rf_read_reg_addr_2}, {mrs1, mrs2});
        s_reset = reset; s_flush = flush; s_ordy = out_ready; s_wb = wb_en;
        s_rs1 = in_rs1; s_rs2 = in_rs2; s_tag = in_tag; s_wa = wb_addr; s_wd = wb_data;
        @(posedge clk);
        if (s_reset || s_flush) mv = 1'b0;
        else if (acc) begin
            mv = 1'b1; mrs1 = s_rs1; mrs2 = s_rs2; mtag = s_tag;
        end else if (mv && s_ordy) mv = 1'b0;
        if (s_wb && !s_reset && s_wa != 5'd0) arch[s_wa] = s_wd;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            regs[i] = $urandom;
            arch[i] = regs[i];
        end
        regs[3] = 32'h11; arch[3] = 32'h11;
        regs[4] = 32'h22; arch[4] = 32'h22;
        arch[0] = 32'd0;
        mv = 1'b0; mrs1 = '0; mrs2 = '0; mtag = '0;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_tag = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick();
        tick();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b0);
        reset = 1'b0;

        // Basic fetch of x3/x4.
        in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd4; in_tag = 32'hA1;
        tick();
        in_rs1 = 5'd6; in_rs2 = 5'd7; in_tag = 32'hA2;
        #1;
        chk("basic_valid", out_valid, 1'b1);
        chk("basic_rs1", out_rs1_data, 32'h11);
        chk("basic_rs2", out_rs2_data, 32'h22);
        chk("basic_tag", out_tag, 32'hA1);

        // Stall three cycles; writeback to x4 in the second.
        tick();
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hBEEF;
        #1;
        chk("stall_wb_comb", out_rs2_data, 32'hBEEF);
        chk("stall_in_ready", in_ready, 1'b0);
        tick();
        wb_en = 1'b0;
        #1;
        chk("stall_wb_held", out_rs2_data, 32'hBEEF);
        chk("stall_tag", out_tag, 32'hA1);
        tick();

        // Handshake plus accept of rs1=x5 on the same edge x5 is written.
        out_ready = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd0; in_tag = 32'hA3;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD;
        tick();
        wb_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("same_edge_rs1", out_rs1_data, 32'hDEAD);
        chk("same_edge_tag", out_tag, 32'hA3);
        tick();

        // Back-to-back stream with x0 being written throughout.
        out_ready = 1'b1; in_valid = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        for (int i = 0; i < 8; i++) begin
            in_rs1 = (i % 3 == 0) ? 5'd0 : 5'(i);
            in_rs2 = 5'(i);
            in_tag = 32'h100 + i;
            tick();
            chk("b2b_valid", out_valid, 1'b1);
            chk("b2b_tag", out_tag, 32'h100 + i);
            if (i % 3 == 0) chk("b2b_x0", out_rs1_data, 32'd0);
        end
        wb_en = 1'b0;

        // Flush while full with a pending offer.
        flush = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd4; in_tag = 32'hF0;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 1'b0);

        // Reset while full.
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_out", {out_tag, out_rs1_data}, 64'd0);
        chk("rst_mid_rs2", out_rs2_data, 32'd0);

        // Randomized traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom % 64) == 0;
            flush     = ($urandom % 16) == 0;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_rs1    = 5'($urandom % 8);
            in_rs2    = 5'($urandom % 8);
            in_tag    = $urandom;
            wb_en     = (($urandom % 2) == 0) && !reset;
            wb_addr   = 5'($urandom % 8);
            wb_data   = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
